// File: rtl/modular_adder_stream.sv
// Streaming modular adder: c = (a + b) mod Q, or (a + b) * 2^-1 mod Q when halve=1.
// Two-stage pipeline with full-rate throughput and lossless backpressure.
// Forms the add leg of the NTT/INTT butterfly. Halving provides Gentleman-Sande inverse-NTT scaling.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready.
// in_ready depends only on out_valid and out_ready, so there is no path from in_valid.
// While out_valid=1 and out_ready=0, c and out_last hold steady.
module modular_adder_stream #(
  parameter int mod_index = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [29:0] a,
  input  logic [29:0] b,
  input  logic        halve,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [29:0] c,
  output logic        out_last
);

  function automatic logic [29:0] q_select(input int idx);
    case (idx)
      0:       return 30'd1063321601;
      1:       return 30'd1063452673;
      2:       return 30'd1064697857;
      3:       return 30'd1065484289;
      4:       return 30'd1065811969;
      5:       return 30'd1068236801;
      6:       return 30'd1068433409;
      7:       return 30'd1068564481;
      8:       return 30'd1069219841;
      9:       return 30'd1070727169;
      10:      return 30'd1071513601;
      11:      return 30'd1072496641;
      default: return 30'd1073479681;
    endcase
  endfunction

  localparam logic [29:0] Q = q_select(mod_index);
  // For odd r and odd Q: (r + Q) / 2 = (r >> 1) + (Q + 1) / 2.
  localparam logic [29:0] Q_HALF_UP = 30'((31'(Q) + 31'd1) >> 1);

  logic        en;
  logic        s1_valid;
  logic [30:0] s1_sum;
  logic        s1_halve;
  logic        s1_last;
  logic [29:0] r;
  logic [29:0] c_next;

  // The whole pipeline advances together whenever the output slot is free or is being drained.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: full-width 31-bit sum, with halve and last captured alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_halve <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sum   <= {1'b0, a} + {1'b0, b};
      s1_halve <= halve;
      s1_last  <= in_last;
    end
  end

  // Single conditional subtract brings the sum into [0, Q), then an optional exact halving.
  always_comb begin
    r      = '0;
    c_next = '0;
    if (s1_sum >= {1'b0, Q}) begin
      r = 30'(s1_sum - {1'b0, Q});
    end else begin
      r = s1_sum[29:0];
    end
    if (s1_halve) begin
      c_next = {1'b0, r[29:1]} + (r[0] ? Q_HALF_UP : 30'd0);
    end else begin
      c_next = r;
    end
  end

  // Stage 2: output register, which is held while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c         <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      c         <= c_next;
      out_last  <= s1_last;
    end
  end

endmodule
